hs_elastic_buf: RTL and testbench
=================================

Name: hs_elastic_buf

Overview:
- Parametrised successor to the single-stage valid/ready handshake slice (en_i/rdy_to_send upstream, en_o/rdy_to_recieve downstream).
- A DEPTH-entry elastic buffer sustains one beat per clock under back-pressure.
- rdy_to_send is driven from registered state only, so ready paths are cut for timing.
- Optional DEDUP mode absorbs consecutive duplicate words (e.g. 33,33,33,34 -> 33,34), reporting drops on a saturating counter.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 4, buffer entries; power of two, >= 2.
- DEDUP, 0, 1 = drop accepted beats equal to the previous accepted beat.
- CNT_W, 16, width of drop_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- en_i  in  1  upstream valid.
- data_i  in  WIDTH  upstream data.
- rdy_to_send  out  1  ready to upstream.
- en_o  out  1  downstream valid.
- data_out  out  WIDTH  downstream data.
- rdy_to_recieve  in  1  downstream ready.
- level  out  $clog2(DEPTH)+1  stored-entry count, 0..DEPTH.
- drop_cnt  out  CNT_W  number of dropped duplicates, saturating.

Behaviour:
- Reset: sampled only at posedge clk while rst_n=0. Effects:
  - Pointers, level and drop_cnt go to 0; last-valid flag is cleared.
  - Outputs: rdy_to_send=0 during reset, en_o=0, data_out=0.
  - The first cycle after reset release gives rdy_to_send=1.
  - Reset mid-traffic discards all stored beats; no beat is output afterwards.
- Push = en_i & rdy_to_send. Pop = en_o & rdy_to_recieve. Both are evaluated at the same posedge.
- rdy_to_send = (level != DEPTH). It is a function of registered state only and has no combinational path from rdy_to_recieve.
- en_o = (level != 0). data_out = mem[rd_ptr], a registered read; data_out holds stable while en_o=1 and pop=0.
- Latency: a beat pushed into an empty buffer at edge k shows en_o=1 and data_out valid after edge k (1 cycle).
- Throughput: 1 beat/clk when rdy_to_recieve=1 and en_i=1 continuously, at any level < DEPTH.
- Full: push is blocked. Simultaneous pop while full gives level DEPTH-1 next cycle and rdy_to_send=1 the cycle after that edge, i.e. one bubble.
- Empty: no pop. Simultaneous push and pop while non-empty and non-full leaves level unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH without special handling.
- Upstream is required to hold data_i stable while en_i=1 and rdy_to_send=0. The block does not check this.
- DEDUP=1:
  - On push, if last_vld=1 and data_i == last_data, the handshake completes (beat consumed) but is not stored.
  - level is unchanged and drop_cnt increments.
  - last_data/last_vld update on every push, stored or dropped.
  - Reset clears last_vld, so the first beat after reset is always stored.
- DEDUP=0: drop_cnt stays 0 and the last_data logic is removed.
- drop_cnt saturates at 2^CNT_W-1.
- No X on any output after reset.

Test Plan:
- Reset/idle: hold rst_n=0 for 10 clk, release -> rdy_to_send=1, en_o=0, level=0, data_out=0; then en_i=1, data_i=8 for 1 clk -> en_o=1, data_out=8 the next cycle.
- Streaming: DEPTH=4, rdy_to_recieve=1, push 8..27 back-to-back -> 20 beats out in order, 1/clk, level never exceeds 1, no bubbles.
- Back-pressure/full: rdy_to_recieve=0, push 8,9,10,11,12 -> 8..11 accepted, level=4, rdy_to_send=0, 12 held by upstream; raise rdy_to_recieve -> output 8,9,10,11,12 in order, 12 accepted exactly once.
- Simultaneous at full: level=4, en_i=1, rdy_to_recieve=1 for one clk -> level=3 and rdy_to_send=1 next cycle; wrap check over 3 full fill/drain cycles gives correct order.
- DEDUP=1: push 33,33,33,34,34,35 -> out 33,34,35, drop_cnt=3; reset then push 35 -> 35 stored, drop_cnt=0.
- Reset mid-operation: level=3, assert rst_n=0 for 1 clk -> en_o=0, level=0 next cycle; no stale beats output after release.

Source files
------------

// File: rtl/hs_elastic_buf.sv
// hs_elastic_buf: DEPTH-entry valid/ready elastic buffer with registered
// ready, registered head-of-queue output and optional duplicate absorption.
module hs_elastic_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int DEDUP = 0,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       rdy_to_send,
    output logic                       en_o,
    output logic [WIDTH-1:0]           data_out,
    input  logic                       rdy_to_recieve,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    lvl_pop;
    logic [LW-1:0]    lvl_nxt;
    logic             rdy_q;
    logic             push;
    logic             pop;
    logic             dup;
    logic             store;
    logic [WIDTH-1:0] head_nxt;

    assign push        = en_i & rdy_q;
    assign pop         = (level_q != '0) & rdy_to_recieve;
    assign store       = push & ~dup;
    assign rdy_to_send = rdy_q;
    assign en_o        = (level_q != '0);
    assign level       = level_q;

    always_comb begin
        lvl_pop  = level_q - LW'(pop);
        lvl_nxt  = lvl_pop + LW'(store);
        rd_nxt   = rd_ptr + AW'(pop);
        // An empty-after-pop buffer forwards the incoming word as the new head
        head_nxt = (lvl_pop == '0) ? data_i : mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            rdy_q    <= 1'b0;
            data_out <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(store);
            rd_ptr  <= rd_nxt;
            level_q <= lvl_nxt;
            rdy_q   <= (lvl_nxt != FULL);
            if (lvl_nxt != '0) begin
                data_out <= head_nxt;
            end
        end
    end

    if (DEDUP != 0) begin : g_dedup
        logic [WIDTH-1:0] last_data;
        logic             last_vld;
        logic [CNT_W-1:0] cnt;

        assign dup      = push & last_vld & (data_i == last_data);
        assign drop_cnt = cnt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                last_data <= '0;
                last_vld  <= 1'b0;
                cnt       <= '0;
            end else begin
                if (push) begin
                    last_data <= data_i;
                    last_vld  <= 1'b1;
                end
                if (dup && (cnt != '1)) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end else begin : g_nodedup
        assign dup      = 1'b0;
        assign drop_cnt = '0;
    end

endmodule

// File: tb/tb_hs_elastic_buf.sv
// Bench for hs_elastic_buf: a plain instance and a DEDUP instance share
// stimulus and are checked against queue models plus literal expectations.
module tb_hs_elastic_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic [31:0] data_i;
    logic        rdy_recv;

    logic        rdy_w  [2];
    logic        en_o_w [2];
    logic [31:0] dout_w [2];
    logic [2:0]  lvl_w  [2];
    logic [15:0] drop_w [2];

    int total = 0;
    int bad = 0;

    logic [31:0] olog0[$];
    logic [31:0] olog1[$];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : m
        localparam int CW = (g == 1) ? 3 : 16;
        localparam int SAT = (1 << CW) - 1;
        logic [CW-1:0] dc;
        logic [31:0]   q[$];
        logic [31:0]   last;
        bit            lastv;
        int            drop;
        bit            rdy;
        bit            ok = 1'b0;
        bit            pu;
        bit            po;

        hs_elastic_buf #(
            .WIDTH(32), .DEPTH(4), .DEDUP(g), .CNT_W(CW)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .en_i(en_i),
            .data_i(data_i),
            .rdy_to_send(rdy_w[g]),
            .en_o(en_o_w[g]),
            .data_out(dout_w[g]),
            .rdy_to_recieve(rdy_recv),
            .level(lvl_w[g]),
            .drop_cnt(dc)
        );
        assign drop_w[g] = 16'(dc);

        always @(posedge clk) begin
            if (!rst_n) begin
                q.delete();
                lastv = 1'b0;
                drop = 0;
                rdy = 1'b0;
                ok = 1'b1;
            end else begin
                pu = en_i && rdy;
                po = (q.size() != 0) && rdy_recv;
                if (po) void'(q.pop_front());
                if (pu) begin
                    if (g == 1 && lastv && data_i == last) begin
                        if (drop < SAT) drop++;
                    end else begin
                        q.push_back(data_i);
                    end
                    last = data_i;
                    lastv = 1'b1;
                end
                rdy = (q.size() != 4);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (en_o_w[0] && rdy_recv) olog0.push_back(dout_w[0]);
            if (en_o_w[1] && rdy_recv) olog1.push_back(dout_w[1]);
        end
    end

    always @(negedge clk) begin
        if (m[0].ok && m[1].ok) begin
            chk("m0_en", 64'(en_o_w[0]), 64'(m[0].q.size() != 0));
            chk("m0_lvl", 64'(lvl_w[0]), 64'(m[0].q.size()));
            chk("m0_rdy", 64'(rdy_w[0]), 64'(m[0].rdy));
            chk("m0_drop", 64'(drop_w[0]), 64'(m[0].drop));
            if (m[0].q.size() != 0) chk("m0_data", 64'(dout_w[0]), 64'(m[0].q[0]));
            chk("m1_en", 64'(en_o_w[1]), 64'(m[1].q.size() != 0));
            chk("m1_lvl", 64'(lvl_w[1]), 64'(m[1].q.size()));
            chk("m1_rdy", 64'(rdy_w[1]), 64'(m[1].rdy));
            chk("m1_drop", 64'(drop_w[1]), 64'(m[1].drop));
            if (m[1].q.size() != 0) chk("m1_data", 64'(dout_w[1]), 64'(m[1].q[0]));
        end
    end

    // Presents d and returns at the negedge after the accepting edge
    task automatic send(input logic [31:0] d);
        bit acc;
        en_i = 1'b1;
        data_i = d;
        for (int i = 0; i < 50; i++) begin
            acc = rdy_w[0];
            @(negedge clk);
            if (acc) return;
        end
        total++;
        bad++;
        $display("FAIL send_timeout: data %0d never accepted", d);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en_i = 1'b0;
        data_i = '0;
        rdy_recv = 1'b0;

        // reset / idle
        repeat (10) @(negedge clk);
        chk("rst_rdy0", 64'(rdy_w[0]), 64'd0);
        chk("rst_en0", 64'(en_o_w[0]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rdy", 64'(rdy_w[0]), 64'd1);
        chk("idle_en", 64'(en_o_w[0]), 64'd0);
        chk("idle_lvl", 64'(lvl_w[0]), 64'd0);
        chk("idle_dout", 64'(dout_w[0]), 64'd0);
        en_i = 1'b1;
        data_i = 32'd8;
        @(negedge clk);
        en_i = 1'b0;
        chk("first_en", 64'(en_o_w[0]), 64'd1);
        chk("first_dout", 64'(dout_w[0]), 64'd8);
        chk("first_dout1", 64'(dout_w[1]), 64'd8);
        rdy_recv = 1'b1;
        @(negedge clk);
        chk("first_drain", 64'(en_o_w[0]), 64'd0);
        do_reset(1);
        @(negedge clk);

        // streaming 8..27
        olog0.delete();
        olog1.delete();
        for (int i = 8; i < 28; i++) begin
            en_i = 1'b1;
            data_i = 32'(i);
            @(negedge clk);
            chk("stream_lvl", 64'(lvl_w[0] <= 3'd1), 64'd1);
        end
        en_i = 1'b0;
        @(negedge clk);
        chk("stream_cnt0", 64'(olog0.size()), 64'd20);
        chk("stream_cnt1", 64'(olog1.size()), 64'd20);
        for (int i = 0; i < 20 && i < olog0.size(); i++)
            chk("stream_ord", 64'(olog0[i]), 64'(i + 8));

        // back-pressure, full, simultaneous push/pop at full
        olog0.delete();
        olog1.delete();
        rdy_recv = 1'b0;
        for (int i = 8; i < 12; i++) send(32'(i));
        en_i = 1'b1;
        data_i = 32'd12;
        @(negedge clk);
        chk("bp_lvl4", 64'(lvl_w[0]), 64'd4);
        chk("bp_rdy0", 64'(rdy_w[0]), 64'd0);
        rdy_recv = 1'b1;
        @(negedge clk);
        chk("full_pop_lvl", 64'(lvl_w[0]), 64'd3);
        chk("full_pop_rdy", 64'(rdy_w[0]), 64'd1);
        @(negedge clk);
        en_i = 1'b0;
        chk("pushpop_lvl", 64'(lvl_w[0]), 64'd3);
        repeat (6) @(negedge clk);
        chk("bp_cnt", 64'(olog0.size()), 64'd5);
        for (int i = 0; i < 5 && i < olog0.size(); i++)
            chk("bp_ord", 64'(olog0[i]), 64'(i + 8));

        // wrap over three fill/drain cycles
        olog0.delete();
        olog1.delete();
        for (int c = 0; c < 3; c++) begin
            rdy_recv = 1'b0;
            for (int k = 0; k < 4; k++) send(32'(100 + c * 4 + k));
            en_i = 1'b0;
            chk("wrap_full", 64'(lvl_w[0]), 64'd4);
            rdy_recv = 1'b1;
            repeat (5) @(negedge clk);
        end
        chk("wrap_cnt", 64'(olog0.size()), 64'd12);
        for (int i = 0; i < 12 && i < olog0.size(); i++)
            chk("wrap_ord", 64'(olog0[i]), 64'(100 + i));

        // duplicate absorption
        olog0.delete();
        olog1.delete();
        send(32'd33);
        send(32'd33);
        send(32'd33);
        send(32'd34);
        send(32'd34);
        send(32'd35);
        en_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("dd_cnt1", 64'(olog1.size()), 64'd3);
        if (olog1.size() == 3) begin
            chk("dd_o0", 64'(olog1[0]), 64'd33);
            chk("dd_o1", 64'(olog1[1]), 64'd34);
            chk("dd_o2", 64'(olog1[2]), 64'd35);
        end
        chk("dd_drop", 64'(drop_w[1]), 64'd3);
        chk("dd_cnt0", 64'(olog0.size()), 64'd6);
        chk("nodd_drop", 64'(drop_w[0]), 64'd0);
        do_reset(1);
        olog1.delete();
        send(32'd35);
        en_i = 1'b0;
        chk("dd_rst_en", 64'(en_o_w[1]), 64'd1);
        chk("dd_rst_dout", 64'(dout_w[1]), 64'd35);
        chk("dd_rst_drop", 64'(drop_w[1]), 64'd0);
        for (int i = 0; i < 9; i++) send(32'd35);
        en_i = 1'b0;
        @(negedge clk);
        chk("dd_sat", 64'(drop_w[1]), 64'd7);
        chk("dd_sat_out", 64'(olog1.size()), 64'd1);

        // reset mid-operation
        olog0.delete();
        olog1.delete();
        rdy_recv = 1'b0;
        send(32'd1);
        send(32'd2);
        send(32'd3);
        en_i = 1'b0;
        chk("mid_lvl3", 64'(lvl_w[0]), 64'd3);
        do_reset(1);
        chk("mid_en", 64'(en_o_w[0]), 64'd0);
        chk("mid_lvl", 64'(lvl_w[0]), 64'd0);
        chk("mid_lvl1", 64'(lvl_w[1]), 64'd0);
        rdy_recv = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_stale0", 64'(olog0.size()), 64'd0);
        chk("mid_stale1", 64'(olog1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
